driver_latency_monitor: RTL and testbench

//  Multi-channel successor to the driver address/vector monitor. For each of NUM_CH FIFO channels,

---
 rtl/driver_mon_pkg.sv | 36 +++
 rtl/lat_stamp_fifo.sv | 57 +++++
 rtl/driver_latency_monitor.sv | 171 +++++++++++++++++
 tb/tb_driver_latency_monitor.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/driver_mon_pkg.sv
// Shared definitions for the driver latency monitor.
//   - default configuration values for the monitor parameters
//   - slave address map offsets and status word bit positions
//   - clog2 helper usable in constant expressions
package driver_mon_pkg;

  localparam int NUM_CH_DEF         = 2;
  localparam int STAMP_DEPTH_DEF    = 16;
  localparam int BIN_RANGE_DEF      = 8;
  localparam int NUM_BINS_DEF       = 16;
  localparam int BIN_CNT_SIZE_DEF   = 16;
  localparam int CYCLE_CNT_SIZE_DEF = 32;

  // Slave word address map (default configuration).
  localparam int BIN_BASE    = 0;
  localparam int STATUS_BASE = BIN_BASE + NUM_CH_DEF * NUM_BINS_DEF;
  localparam int CYCLE_ADDR  = STATUS_BASE + NUM_CH_DEF;

  // Status word layout: {14'b0, underflow, overflow, words_in_fifo[15:0]}.
  localparam int WORDS_W      = 16;
  localparam int STAT_OVF_BIT = 16;
  localparam int STAT_UNF_BIT = 17;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/lat_stamp_fifo.sv
// Timestamp FIFO for one monitored channel.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   clear           synchronous flush (run start)
//   push, push_data write a timestamp (caller never pushes into a full FIFO
//                   unless it pops in the same cycle)
//   pop             drop the head entry (caller never pops when empty)
//   head            oldest timestamp, valid when !empty
//   full, empty     occupancy status
module lat_stamp_fifo
  import driver_mon_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // On a simultaneous pop+push while full, the write lands in the slot being
  // vacated; head is read combinationally before that edge, so it is safe.
  assign head  = mem[rd_ptr_reg[AW-1:0]];
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

endmodule

// File: rtl/driver_latency_monitor.sv
// Per-channel FIFO residency latency monitor with histogram readout.
// Ports:
//   clk, reset               clock and synchronous active-high reset
//   run_program/end_program  measurement window start/stop pulses
//   ch_wr/ch_rd              per-channel FIFO write/read strobes
//   slave_addr/slave_rd      word-addressed register read request
//   slave_data_out           read data, registered, held between reads
//   active_program           measurement window open
//   cycle_cnt                cycles since run start
//   words_in_fifo            per-channel occupancy (16 bits each, ch0 lowest)
//   ch_overflow/underflow    sticky per-channel error flags
module driver_latency_monitor
  import driver_mon_pkg::*;
#(
  parameter int NUM_CH         = NUM_CH_DEF,
  parameter int STAMP_DEPTH    = STAMP_DEPTH_DEF,
  parameter int BIN_RANGE      = BIN_RANGE_DEF,
  parameter int NUM_BINS       = NUM_BINS_DEF,
  parameter int BIN_CNT_SIZE   = BIN_CNT_SIZE_DEF,
  parameter int CYCLE_CNT_SIZE = CYCLE_CNT_SIZE_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        run_program,
  input  logic                        end_program,
  input  logic [NUM_CH-1:0]           ch_wr,
  input  logic [NUM_CH-1:0]           ch_rd,
  input  logic [31:0]                 slave_addr,
  input  logic                        slave_rd,
  output logic [31:0]                 slave_data_out,
  output logic                        active_program,
  output logic [CYCLE_CNT_SIZE-1:0]   cycle_cnt,
  output logic [NUM_CH*WORDS_W-1:0]   words_in_fifo,
  output logic [NUM_CH-1:0]           ch_overflow,
  output logic [NUM_CH-1:0]           ch_underflow
);

  localparam int SHIFT       = clog2(BIN_RANGE);
  localparam int TOTAL_BINS  = NUM_CH * NUM_BINS;
  localparam int STATUS_ADDR = BIN_BASE + TOTAL_BINS;
  localparam int CYC_ADDR    = STATUS_ADDR + NUM_CH;
  localparam int IDX_W       = (TOTAL_BINS > 1) ? clog2(TOTAL_BINS) : 1;
  localparam int BW          = (NUM_BINS > 1) ? clog2(NUM_BINS) : 1;

  logic                      active_reg;
  logic [CYCLE_CNT_SIZE-1:0] cycle_reg;
  logic                      start;
  logic [TOTAL_BINS-1:0][BIN_CNT_SIZE-1:0] bin_cnt;
  logic [31:0]               rd_data;

  // A run pulse only restarts the measurement when the window is closed.
  assign start = run_program & ~active_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      active_reg <= 1'b0;
      cycle_reg  <= '0;
    end else begin
      active_reg <= ~end_program & (active_reg | run_program);
      if (start)           cycle_reg <= '0;
      else if (active_reg) cycle_reg <= cycle_reg + 1'b1;
    end
  end

  assign active_program = active_reg;
  assign cycle_cnt      = cycle_reg;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic                      wr_en, rd_en;
    logic                      push, pop, full, empty;
    logic [CYCLE_CNT_SIZE-1:0] head, latency, lat_reg, lat_shift;
    logic                      lat_take, lat_vld_reg;
    logic                      ovf_reg, unf_reg;
    logic [WORDS_W-1:0]        words_reg;
    logic [BW-1:0]             bin_idx;

    assign wr_en = ch_wr[gi] & active_reg;
    assign rd_en = ch_rd[gi] & active_reg;

    // wr+rd on an empty FIFO bypasses storage (latency 0); on a full FIFO
    // the pop frees the slot the push needs.
    assign push     = wr_en & (rd_en ? ~empty : ~full);
    assign pop      = rd_en & ~empty;
    assign lat_take = rd_en & (~empty | wr_en);
    assign latency  = (wr_en & rd_en & empty) ? '0 : cycle_reg - head;

    lat_stamp_fifo #(
      .WIDTH (CYCLE_CNT_SIZE),
      .DEPTH (STAMP_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .clear     (start),
      .push      (push),
      .pop       (pop),
      .push_data (cycle_reg),
      .head      (head),
      .full      (full),
      .empty     (empty)
    );

    always_ff @(posedge clk) begin
      if (reset) begin
        lat_reg     <= '0;
        lat_vld_reg <= 1'b0;
        ovf_reg     <= 1'b0;
        unf_reg     <= 1'b0;
        words_reg   <= '0;
      end else begin
        lat_vld_reg <= lat_take;
        if (lat_take) lat_reg <= latency;
        if (start) begin
          ovf_reg <= 1'b0;
          unf_reg <= 1'b0;
        end else begin
          if (wr_en & ~rd_en & full)  ovf_reg <= 1'b1;
          if (rd_en & ~wr_en & empty) unf_reg <= 1'b1;
        end
        // Occupancy follows the raw strobes, independent of the window.
        if (ch_wr[gi] & ~ch_rd[gi] & (words_reg != '1))
          words_reg <= words_reg + 1'b1;
        else if (ch_rd[gi] & ~ch_wr[gi] & (words_reg != '0))
          words_reg <= words_reg - 1'b1;
      end
    end

    assign lat_shift = lat_reg >> SHIFT;
    assign bin_idx   = (lat_shift >= CYCLE_CNT_SIZE'(NUM_BINS - 1)) ?
                       BW'(NUM_BINS - 1) : lat_shift[BW-1:0];

    for (genvar bj = 0; bj < NUM_BINS; bj++) begin : g_bin
      logic [BIN_CNT_SIZE-1:0] cnt_reg;
      // An overflowed channel's histogram is frozen until the next run.
      always_ff @(posedge clk) begin
        if (reset || start)
          cnt_reg <= '0;
        else if (lat_vld_reg && !ovf_reg && (bin_idx == BW'(bj)) && (cnt_reg != '1))
          cnt_reg <= cnt_reg + 1'b1;
      end
      assign bin_cnt[gi*NUM_BINS + bj] = cnt_reg;
    end

    assign words_in_fifo[gi*WORDS_W +: WORDS_W] = words_reg;
    assign ch_overflow[gi]  = ovf_reg;
    assign ch_underflow[gi] = unf_reg;
  end

  // Bin counters occupy addresses from BIN_BASE (0) upward.
  always_comb begin
    rd_data = '0;
    if (slave_addr < 32'(STATUS_ADDR)) begin
      rd_data = 32'(bin_cnt[slave_addr[IDX_W-1:0]]);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (slave_addr == 32'(STATUS_ADDR + c)) begin
        rd_data[WORDS_W-1:0]  = words_in_fifo[c*WORDS_W +: WORDS_W];
        rd_data[STAT_OVF_BIT] = ch_overflow[c];
        rd_data[STAT_UNF_BIT] = ch_underflow[c];
      end
    end
    if (slave_addr == 32'(CYC_ADDR)) begin
      rd_data = 32'(cycle_reg);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)         slave_data_out <= '0;
    else if (slave_rd) slave_data_out <= rd_data;
  end

endmodule

// File: tb/tb_driver_latency_monitor.sv
// Directed bench for driver_latency_monitor. Narrow bin and cycle counters
// keep saturation and counter wrap reachable in a short run.
module tb_driver_latency_monitor;

  localparam int NUM_CH = 2;
  localparam int BCW    = 4;
  localparam int CCW    = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              run_program = 1'b0;
  logic              end_program = 1'b0;
  logic [1:0]        ch_wr = '0;
  logic [1:0]        ch_rd = '0;
  logic [31:0]       slave_addr = '0;
  logic              slave_rd = 1'b0;
  logic [31:0]       slave_data_out;
  logic              active_program;
  logic [CCW-1:0]    cycle_cnt;
  logic [31:0]       words_in_fifo;
  logic [1:0]        ch_overflow;
  logic [1:0]        ch_underflow;

  int checks = 0;
  int errors = 0;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  driver_latency_monitor #(
    .NUM_CH         (NUM_CH),
    .STAMP_DEPTH    (16),
    .BIN_RANGE      (8),
    .NUM_BINS       (16),
    .BIN_CNT_SIZE   (BCW),
    .CYCLE_CNT_SIZE (CCW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .run_program    (run_program),
    .end_program    (end_program),
    .ch_wr          (ch_wr),
    .ch_rd          (ch_rd),
    .slave_addr     (slave_addr),
    .slave_rd       (slave_rd),
    .slave_data_out (slave_data_out),
    .active_program (active_program),
    .cycle_cnt      (cycle_cnt),
    .words_in_fifo  (words_in_fifo),
    .ch_overflow    (ch_overflow),
    .ch_underflow   (ch_underflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_run();
    run_program = 1'b1; tick(); run_program = 1'b0;
  endtask

  task automatic pulse_end();
    end_program = 1'b1; tick(); end_program = 1'b0;
  endtask

  task automatic strobe(input logic [1:0] wr, input logic [1:0] rd);
    ch_wr = wr; ch_rd = rd; tick(); ch_wr = '0; ch_rd = '0;
  endtask

  task automatic slave_read(input int addr, output logic [31:0] d);
    slave_addr = 32'(addr); slave_rd = 1'b1; tick(); slave_rd = 1'b0;
    d = slave_data_out;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle(3); reset = 1'b0; idle(1);
    checks++; if (active_program !== 1'b0) begin errors++; $display("FAIL reset_active got %0h expected 0", active_program); end
    checks++; if (cycle_cnt !== 8'h00) begin errors++; $display("FAIL reset_cycle got %0h expected 0", cycle_cnt); end
    checks++; if (words_in_fifo !== 32'h0) begin errors++; $display("FAIL reset_words got %0h expected 0", words_in_fifo); end
    checks++; if ({ch_overflow, ch_underflow} !== 4'h0) begin errors++; $display("FAIL reset_flags got %0h expected 0", {ch_overflow, ch_underflow}); end
    checks++; if (slave_data_out !== 32'h0) begin errors++; $display("FAIL reset_sdo got %0h expected 0", slave_data_out); end
    slave_read(2, rdata);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_bin got %0h expected 0", rdata); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    pulse_run();
    checks++; if (active_program !== 1'b1) begin errors++; $display("FAIL run_active got %0h expected 1", active_program); end
    idle(3);
    checks++; if (cycle_cnt !== 8'd3) begin errors++; $display("FAIL run_cycle got %0h expected 3", cycle_cnt); end
    strobe(2'b01, 2'b00);
    checks++; if (words_in_fifo[15:0] !== 16'd1) begin errors++; $display("FAIL basic_words1 got %0h expected 1", words_in_fifo[15:0]); end
    idle(19);
    strobe(2'b00, 2'b01);
    idle(2);
    checks++; if (words_in_fifo[15:0] !== 16'd0) begin errors++; $display("FAIL basic_words0 got %0h expected 0", words_in_fifo[15:0]); end
    slave_read(2, rdata);
    checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL basic_bin2 got %0h expected 1", rdata); end
    slave_read(1, rdata);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL basic_bin1 got %0h expected 0", rdata); end
    slave_read(3, rdata);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL basic_bin3 got %0h expected 0", rdata); end
    slave_read(18, rdata);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL basic_ch1_bin2 got %0h expected 0", rdata); end
    $display("test_basic done");
  endtask

  task automatic test_clamp_saturate();
    for (int rep = 0; rep < 20; rep++) begin
      strobe(2'b10, 2'b00);
      idle(199);
      strobe(2'b00, 2'b10);
      if (rep == 0) begin
        idle(2);
        slave_read(31, rdata);
        checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL clamp_bin15 got %0h expected 1", rdata); end
      end
    end
    idle(2);
    slave_read(31, rdata);
    checks++; if (rdata !== 32'hF) begin errors++; $display("FAIL sat_bin15 got %0h expected f", rdata); end
    slave_read(25, rdata);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL clamp_bin9 got %0h expected 0", rdata); end
    slave_read(30, rdata);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL clamp_bin14 got %0h expected 0", rdata); end
    $display("test_clamp_saturate done");
  endtask

  task automatic test_same_cycle();
    strobe(2'b01, 2'b01);
    idle(2);
    slave_read(0, rdata);
    checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL bypass_bin0 got %0h expected 1", rdata); end
    checks++; if (ch_underflow[0] !== 1'b0) begin errors++; $display("FAIL bypass_unf got %0h expected 0", ch_underflow[0]); end
    strobe(2'b00, 2'b01);
    idle(2);
    checks++; if (ch_underflow[0] !== 1'b1) begin errors++; $display("FAIL unf_set got %0h expected 1", ch_underflow[0]); end
    checks++; if (words_in_fifo[15:0] !== 16'd0) begin errors++; $display("FAIL words_floor got %0h expected 0", words_in_fifo[15:0]); end
    slave_read(0, rdata);
    checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL unf_bin0 got %0h expected 1", rdata); end
    slave_read(32, rdata);
    checks++; if (rdata !== 32'h0002_0000) begin errors++; $display("FAIL unf_status got %0h expected 20000", rdata); end
    $display("test_same_cycle done");
  endtask

  task automatic test_overflow();
    repeat (16) strobe(2'b01, 2'b00);
    checks++; if (ch_overflow[0] !== 1'b0) begin errors++; $display("FAIL ovf_at16 got %0h expected 0", ch_overflow[0]); end
    strobe(2'b01, 2'b00);
    checks++; if (ch_overflow[0] !== 1'b1) begin errors++; $display("FAIL ovf_at17 got %0h expected 1", ch_overflow[0]); end
    checks++; if (words_in_fifo[15:0] !== 16'd17) begin errors++; $display("FAIL ovf_words got %0h expected 11", words_in_fifo[15:0]); end
    strobe(2'b00, 2'b01);
    idle(2);
    slave_read(2, rdata);
    checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL freeze_bin2 got %0h expected 1", rdata); end
    slave_read(32, rdata);
    checks++; if (rdata !== 32'h0003_0010) begin errors++; $display("FAIL ovf_status got %0h expected 30010", rdata); end
    pulse_end();
    repeat (16) strobe(2'b00, 2'b01);
    checks++; if (words_in_fifo[15:0] !== 16'd0) begin errors++; $display("FAIL drain_words got %0h expected 0", words_in_fifo[15:0]); end
    checks++; if (ch_underflow[0] !== 1'b1) begin errors++; $display("FAIL idle_unf got %0h expected 1", ch_underflow[0]); end
    pulse_run();
    checks++; if ({ch_overflow, ch_underflow} !== 4'h0) begin errors++; $display("FAIL rerun_flags got %0h expected 0", {ch_overflow, ch_underflow}); end
    slave_read(2, rdata);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rerun_bin2 got %0h expected 0", rdata); end
    slave_read(31, rdata);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rerun_ch1_bin15 got %0h expected 0", rdata); end
    $display("test_overflow done");
  endtask

  task automatic test_window();
    pulse_end();
    pulse_run();
    idle(4);
    pulse_run();
    checks++; if (cycle_cnt !== 8'd5) begin errors++; $display("FAIL rerun_ignored got %0h expected 5", cycle_cnt); end
    idle(4);
    pulse_end();
    checks++; if (active_program !== 1'b0) begin errors++; $display("FAIL end_active got %0h expected 0", active_program); end
    idle(5);
    checks++; if (cycle_cnt !== 8'd10) begin errors++; $display("FAIL frozen_cycle got %0h expected a", cycle_cnt); end
    slave_read(34, rdata);
    checks++; if (rdata !== 32'd10) begin errors++; $display("FAIL cycle_addr got %0h expected a", rdata); end
    idle(3);
    checks++; if (slave_data_out !== 32'd10) begin errors++; $display("FAIL sdo_hold got %0h expected a", slave_data_out); end
    run_program = 1'b1; end_program = 1'b1; tick(); run_program = 1'b0; end_program = 1'b0;
    checks++; if (active_program !== 1'b0) begin errors++; $display("FAIL run_end_active got %0h expected 0", active_program); end
    $display("test_window done");
  endtask

  task automatic test_wrap_reset();
    pulse_run();
    idle(252);
    strobe(2'b01, 2'b00);
    idle(9);
    strobe(2'b00, 2'b01);
    checks++; if (cycle_cnt !== 8'd7) begin errors++; $display("FAIL wrap_cycle got %0h expected 7", cycle_cnt); end
    idle(2);
    slave_read(1, rdata);
    checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL wrap_bin1 got %0h expected 1", rdata); end
    slave_read(15, rdata);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL wrap_bin15 got %0h expected 0", rdata); end
    repeat (3) strobe(2'b01, 2'b00);
    checks++; if (words_in_fifo[15:0] !== 16'd3) begin errors++; $display("FAIL mid_words got %0h expected 3", words_in_fifo[15:0]); end
    strobe(2'b00, 2'b01);
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (active_program !== 1'b0) begin errors++; $display("FAIL mid_reset_active got %0h expected 0", active_program); end
    checks++; if (cycle_cnt !== 8'h0) begin errors++; $display("FAIL mid_reset_cycle got %0h expected 0", cycle_cnt); end
    checks++; if (words_in_fifo !== 32'h0) begin errors++; $display("FAIL mid_reset_words got %0h expected 0", words_in_fifo); end
    checks++; if (slave_data_out !== 32'h0) begin errors++; $display("FAIL mid_reset_sdo got %0h expected 0", slave_data_out); end
    idle(2);
    slave_read(0, rdata);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL mid_reset_bin0 got %0h expected 0", rdata); end
    slave_read(1, rdata);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL mid_reset_bin1 got %0h expected 0", rdata); end
    $display("test_wrap_reset done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp_saturate();
    test_same_cycle();
    test_overflow();
    test_window();
    test_wrap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
